// File: rtl/result_mux_pipe.sv
// Result selection stage: picks the ALU/shifter/HI/LO result named by the funct code and
// registers it behind a valid/ready handshake, stalling MFHI/MFLO while the multiplier is busy.
//
// state | meaning
// EMPTY | no result held, ready to accept
// HOLD  | data_out valid, waiting for consumer (pass-through accept when out_ready)
// STALL | MFHI/MFLO accepted while multiplier busy, waiting for HI/LO
module result_mux_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [WIDTH-1:0] hi_out,
    input  logic [WIDTH-1:0] lo_out,
    input  logic [WIDTH-1:0] shifter_out,
    input  logic             cout,
    input  logic [5:0]       signal,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mul_busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             out_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MFLO = 6'b010010;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t           r_state;
    logic [5:0]       r_pend;
    logic [WIDTH-1:0] r_data;
    logic             r_err;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_err;
    logic             w_is_hilo;
    logic [WIDTH-1:0] w_pend_data;
    logic             w_accept;
    logic             w_cnt_sat;

    always_comb begin
        w_sel_data = '0;
        w_sel_err  = 1'b0;
        case (signal)
            F_AND, F_OR, F_ADD, F_SUB: w_sel_data = alu_out;
            F_SLT:                     w_sel_data = {{(WIDTH-1){1'b0}}, ~cout};
            F_SLL:                     w_sel_data = shifter_out;
            F_MFHI:                    w_sel_data = hi_out;
            F_MFLO:                    w_sel_data = lo_out;
            default:                   w_sel_err  = 1'b1;
        endcase
    end

    assign w_is_hilo   = (signal == F_MFHI) || (signal == F_MFLO);
    assign w_pend_data = (r_pend == F_MFHI) ? hi_out : lo_out;
    assign w_cnt_sat   = (r_stall_cnt == {CNT_W{1'b1}});

    // Only in_ready is combinational: HOLD forwards the consumer's ready for 1/cycle throughput.
    assign in_ready = (r_state == ST_EMPTY) || ((r_state == ST_HOLD) && out_ready);
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_EMPTY;
            r_pend      <= '0;
            r_data      <= '0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            case (r_state)
                ST_EMPTY, ST_HOLD: begin
                    if (w_accept) begin
                        if (w_is_hilo && mul_busy) begin
                            // data_out/out_err keep their old values while waiting
                            r_pend      <= signal;
                            r_state     <= ST_STALL;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_data      <= w_sel_data;
                            r_err       <= w_sel_err;
                            r_state     <= ST_HOLD;
                            r_out_valid <= 1'b1;
                        end
                    end else if ((r_state == ST_HOLD) && out_ready) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                ST_STALL: begin
                    if (!w_cnt_sat) begin
                        r_stall_cnt <= r_stall_cnt + 1'b1;
                    end
                    if (!mul_busy) begin
                        r_data      <= w_pend_data;
                        r_err       <= 1'b0;
                        r_state     <= ST_HOLD;
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign data_out  = r_data;
    assign out_err   = r_err;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_result_mux_pipe.sv
// Self-checking bench for result_mux_pipe: directed scenarios plus randomized traffic
// against a behavioural result/handshake model; a CNT_W=2 copy checks counter saturation.
module tb_result_mux_pipe;

    localparam int W = 32;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MFLO = 6'b010010;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] alu_out = '0, hi_out = '0, lo_out = '0, shifter_out = '0;
    logic         cout = 1'b0;
    logic [5:0]   signal = '0;
    logic         in_valid = 1'b0, mul_busy = 1'b0, out_ready = 1'b0;
    logic         in_ready, out_valid, out_err;
    logic [W-1:0] data_out;
    logic [7:0]   stall_cnt;
    logic         in_ready2, out_valid2, out_err2;
    logic [W-1:0] data_out2;
    logic [1:0]   stall_cnt2;

    int total = 0;
    int bad   = 0;

    // reference model: result held/awaited, captured data, cumulative stall cycles
    bit           m_have, m_wait;
    logic [5:0]   m_pend;
    logic [W-1:0] m_data;
    logic         m_err;
    int           m_stalls;

    always #5 clk = ~clk;

    result_mux_pipe #(.WIDTH(W), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .alu_out(alu_out), .hi_out(hi_out), .lo_out(lo_out),
        .shifter_out(shifter_out), .cout(cout), .signal(signal), .in_valid(in_valid),
        .in_ready(in_ready), .mul_busy(mul_busy), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .out_err(out_err), .stall_cnt(stall_cnt)
    );

    result_mux_pipe #(.WIDTH(W), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .alu_out(alu_out), .hi_out(hi_out), .lo_out(lo_out),
        .shifter_out(shifter_out), .cout(cout), .signal(signal), .in_valid(in_valid),
        .in_ready(in_ready2), .mul_busy(mul_busy), .out_valid(out_valid2), .out_ready(out_ready),
        .data_out(data_out2), .out_err(out_err2), .stall_cnt(stall_cnt2)
    );

    function automatic logic [W:0] ref_select(input logic [5:0] code);
        case (code)
            F_AND, F_OR, F_ADD, F_SUB: return {1'b0, alu_out};
            F_SLT:  return {1'b0, 32'(cout ? 0 : 1)};
            F_SLL:  return {1'b0, shifter_out};
            F_MFHI: return {1'b0, hi_out};
            F_MFLO: return {1'b0, lo_out};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    function automatic bit ref_ready();
        return !m_wait && (!m_have || out_ready);
    endfunction

    task automatic model_clear();
        m_have = 0; m_wait = 0; m_pend = '0; m_data = '0; m_err = 0; m_stalls = 0;
    endtask

    task automatic model_edge();
        logic [W:0] sel;
        bit acc;
        acc = in_valid && ref_ready();
        if (m_wait) begin
            m_stalls++;
            if (!mul_busy) begin
                m_wait = 0; m_have = 1; m_err = 0;
                m_data = (m_pend == F_MFHI) ? hi_out : lo_out;
            end
        end else if (acc) begin
            if ((signal == F_MFHI || signal == F_MFLO) && mul_busy) begin
                m_wait = 1; m_have = 0; m_pend = signal;
            end else begin
                sel = ref_select(signal);
                m_have = 1; m_data = sel[W-1:0]; m_err = sel[W];
            end
        end else if (m_have && out_ready) begin
            m_have = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input bit vld, input logic [5:0] code, input logic [W-1:0] alu,
                         input bit busy, input bit ordy);
        in_valid = vld; signal = code; alu_out = alu; mul_busy = busy; out_ready = ordy;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 0;
        in_valid = 0; signal = '0; alu_out = '0; hi_out = '0; lo_out = '0;
        shifter_out = '0; cout = 0; mul_busy = 0; out_ready = 0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 1;
    endtask

    task automatic test_reset();
        do_reset();
        drive(0, F_ADD, 32'h0, 0, 1);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (data_out !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", data_out); end
        total++; if (stall_cnt !== 8'h0) begin bad++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
        // load a result, then reset asynchronously mid-cycle
        drive(1, F_ADD, 32'h77, 0, 0);
        step();
        drive(0, F_ADD, 32'h0, 0, 0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL reset_preload_valid got=%b exp=1", out_valid); end
        #2 reset = 0;
        model_clear();
        #1;
        total++; if (out_valid !== 1'b0 || data_out !== 32'h0 || out_err !== 1'b0) begin
            bad++; $display("FAIL reset_async got valid=%b data=%h err=%b exp 0/0/0", out_valid, data_out, out_err);
        end
        @(negedge clk);
        reset = 1;
    endtask

    task automatic test_add();
        do_reset();
        drive(1, F_ADD, 32'h5, 0, 1);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL add_in_ready got=%b exp=1", in_ready); end
        step();
        drive(0, F_SUB, 32'h9, 0, 1);
        total++; if (out_valid !== 1'b1 || data_out !== 32'h5 || out_err !== 1'b0) begin
            bad++; $display("FAIL add_result got valid=%b data=%h err=%b exp 1/00000005/0", out_valid, data_out, out_err);
        end
        step();
        total++; if (out_valid !== 1'b0 || data_out !== 32'h5) begin
            bad++; $display("FAIL add_drain got valid=%b data=%h exp 0/00000005", out_valid, data_out);
        end
    endtask

    task automatic test_slt_back_to_back();
        do_reset();
        cout = 0;
        drive(1, F_SLT, 32'hFFFF_FFFF, 0, 1);
        step();
        total++; if (out_valid !== 1'b1 || data_out !== 32'h1) begin
            bad++; $display("FAIL slt0_result got valid=%b data=%h exp 1/00000001", out_valid, data_out);
        end
        cout = 1;
        drive(1, F_SLT, 32'hFFFF_FFFF, 0, 1);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL slt_b2b_ready got=%b exp=1", in_ready); end
        step();
        total++; if (out_valid !== 1'b1 || data_out !== 32'h0) begin
            bad++; $display("FAIL slt1_result got valid=%b data=%h exp 1/00000000", out_valid, data_out);
        end
        drive(0, F_SLT, 32'h0, 0, 1);
        step();
    endtask

    task automatic test_mfhi_stall();
        do_reset();
        hi_out = 32'h1111_2222;
        drive(1, F_MFHI, 32'h0, 1, 1);
        step();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) hi_out = 32'hDEAD_BEEF;
            drive(0, F_ADD, 32'h0, (i != 2), 1);
            total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                bad++; $display("FAIL stall_hs cyc=%0d got ready=%b valid=%b exp 0/0", i, in_ready, out_valid);
            end
            total++; if (stall_cnt !== 8'(i)) begin
                bad++; $display("FAIL stall_cnt_run cyc=%0d got=%0d exp=%0d", i, stall_cnt, i);
            end
            step();
        end
        total++; if (out_valid !== 1'b1 || data_out !== 32'hDEAD_BEEF || out_err !== 1'b0) begin
            bad++; $display("FAIL mfhi_result got valid=%b data=%h err=%b exp 1/deadbeef/0", out_valid, data_out, out_err);
        end
        total++; if (stall_cnt !== 8'd3) begin bad++; $display("FAIL mfhi_stall_cnt got=%0d exp=3", stall_cnt); end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1, F_ADD, 32'h11, 0, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1, F_OR, 32'h22, 0, 0);
            total++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || data_out !== 32'h11) begin
                bad++; $display("FAIL bp_hold cyc=%0d got ready=%b valid=%b data=%h exp 0/1/00000011", i, in_ready, out_valid, data_out);
            end
            step();
        end
        drive(1, F_OR, 32'h22, 0, 1);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
        step();
        drive(0, F_OR, 32'h0, 0, 1);
        total++; if (out_valid !== 1'b1 || data_out !== 32'h22) begin
            bad++; $display("FAIL bp_next got valid=%b data=%h exp 1/00000022", out_valid, data_out);
        end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_single got valid=%b exp=0", out_valid); end
    endtask

    task automatic test_invalid_and_saturation();
        do_reset();
        drive(1, 6'b111111, 32'hFFFF, 0, 1);
        step();
        total++; if (out_valid !== 1'b1 || data_out !== 32'h0 || out_err !== 1'b1) begin
            bad++; $display("FAIL bad_code got valid=%b data=%h err=%b exp 1/00000000/1", out_valid, data_out, out_err);
        end
        drive(1, F_MFLO, 32'h0, 1, 1);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(0, F_ADD, 32'h0, 1, 1);
            step();
        end
        lo_out = 32'hCAFE_0123;
        drive(0, F_ADD, 32'h0, 0, 1);
        step();
        total++; if (stall_cnt !== 8'd6) begin bad++; $display("FAIL sat_wide got=%0d exp=6", stall_cnt); end
        total++; if (stall_cnt2 !== 2'd3) begin bad++; $display("FAIL sat_narrow got=%0d exp=3", stall_cnt2); end
        total++; if (data_out !== 32'hCAFE_0123 || out_err !== 1'b0) begin
            bad++; $display("FAIL mflo_result got data=%h err=%b exp cafe0123/0", data_out, out_err);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(1, F_MFHI, 32'h0, 1, 1);
        step();
        drive(0, F_ADD, 32'h0, 1, 1);
        step();
        #2 reset = 0;
        model_clear();
        #1;
        total++; if (out_valid !== 1'b0 || data_out !== 32'h0 || out_err !== 1'b0 || stall_cnt !== 8'h0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL rst_stall got valid=%b data=%h err=%b cnt=%0d ready=%b exp 0/0/0/0/1",
                            out_valid, data_out, out_err, stall_cnt, in_ready);
        end
        @(negedge clk);
        reset = 1;
        hi_out = 32'hBAD0_BAD0;
        for (int i = 0; i < 3; i++) begin
            drive(0, F_ADD, 32'h0, 0, 1);
            total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++; $display("FAIL rst_stall_after cyc=%0d got valid=%b ready=%b exp 0/1", i, out_valid, in_ready);
            end
            step();
        end
    endtask

    task automatic test_random();
        logic [5:0] codes [9];
        int sel;
        codes = '{F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SLL, F_MFHI, F_MFLO, 6'b111111};
        do_reset();
        for (int i = 0; i < 600; i++) begin
            sel = int'($urandom_range(0, 9));
            signal = (sel == 9) ? 6'($urandom) : codes[sel];
            in_valid = ($urandom_range(0, 3) != 0);
            mul_busy = ($urandom_range(0, 4) < 2);
            out_ready = ($urandom_range(0, 9) < 7);
            alu_out = $urandom; hi_out = $urandom; lo_out = $urandom; shifter_out = $urandom;
            cout = 1'($urandom);
            #1;
            total++; if (in_ready !== ref_ready() || in_ready2 !== ref_ready()) begin
                bad++; $display("FAIL rnd_ready cyc=%0d got=%b/%b exp=%b", i, in_ready, in_ready2, ref_ready());
            end
            total++; if (out_valid !== m_have || data_out !== m_data || out_err !== m_err) begin
                bad++; $display("FAIL rnd_out cyc=%0d got valid=%b data=%h err=%b exp %b/%h/%b",
                                i, out_valid, data_out, out_err, m_have, m_data, m_err);
            end
            total++; if (int'(stall_cnt) !== ((m_stalls > 255) ? 255 : m_stalls)
                         || int'(stall_cnt2) !== ((m_stalls > 3) ? 3 : m_stalls)) begin
                bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d stalls=%0d", i, stall_cnt, stall_cnt2, m_stalls);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_slt_back_to_back();
        test_mfhi_stall();
        test_backpressure();
        test_invalid_and_saturation();
        test_reset_mid_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/result_mux_pipe.md
RESULT_MUX_PIPE -- requirements
Module: result_mux_pipe

Interface
REQ-001 Parameter: WIDTH, 32, datapath width of all data inputs and data_out.
REQ-002 Parameter: CNT_W, 8, width of the stall-cycle counter.
REQ-003 Clocking SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: reset  input  1  asynchronous active-low reset.
REQ-006 Port: alu_out  input  WIDTH  ALU result (AND/OR/ADD/SUB).
REQ-007 Port: hi_out  input  WIDTH  HI register value.
REQ-008 Port: lo_out  input  WIDTH  LO register value.
REQ-009 Port: shifter_out  input  WIDTH  shifter result (SLL).
REQ-010 Port: cout  input  1  ALU carry-out; SLT uses ~cout.
REQ-011 Port: signal  input  6  funct code of the offered operation.
REQ-012 Port: in_valid  input  1  operation offered this cycle.
REQ-013 Port: in_ready  output  1  block accepts the offered operation.
REQ-014 Port: mul_busy  input  1  multiplier busy; HI/LO not yet valid.
REQ-015 Port: out_valid  output  1  data_out holds a result.
REQ-016 Port: out_ready  input  1  consumer takes the result.
REQ-017 Port: data_out  output  WIDTH  registered selected result.
REQ-018 Port: out_err  output  1  result came from an unsupported code.
REQ-019 Port: stall_cnt  output  CNT_W  saturating count of cycles spent in STALL.

Function
REQ-020 Selection SHALL use these codes: AND 100100, OR 100101, ADD 100000, and SUB 100010 select alu_out; SLT 101010 selects WIDTH-bit value with bit0=~cout and all other bits 0; SLL 000000 selects shifter_out; MFHI 010000 selects hi_out; MFLO 010010 selects lo_out.
REQ-021 Any other code SHALL produce data_out=0 and out_err=1; supported codes SHALL produce out_err=0.
REQ-022 Control SHALL use FSM states EMPTY, HOLD and STALL.
REQ-023 In EMPTY, the block SHALL drive in_ready=1 and out_valid=0.
REQ-024 In HOLD, the block SHALL drive out_valid=1 and in_ready=out_ready, giving a combinational pass-through accept.
REQ-025 In STALL, the block SHALL drive in_ready=0 and out_valid=0.
REQ-026 An accept SHALL occur when in_valid and in_ready are both 1; inputs are sampled at that rising edge.
REQ-027 An accepted non-HI/LO op, or a MFHI/MFLO accepted with mul_busy=0, SHALL register its result and enter HOLD at the same edge (latency 1 cycle).
REQ-028 An accepted MFHI/MFLO with mul_busy=1 SHALL latch signal into a pending register and enter STALL; data_out is unchanged.
REQ-029 In STALL, at the first edge with mul_busy=0, the block SHALL select hi_out/lo_out per the pending code, sampled at that edge, and enter HOLD.
REQ-030 In HOLD with out_ready=1 and an accept, the block SHALL follow REQ-027/REQ-028, supporting back-to-back results at one per cycle.
REQ-031 In HOLD with out_ready=1 and no accept, the block SHALL enter EMPTY; data_out keeps its last value.
REQ-032 In HOLD with out_ready=0, data_out and out_err SHALL remain stable and nothing is accepted.
REQ-033 stall_cnt SHALL increment once per clock spent in STALL, saturate at 2^CNT_W-1, and never wrap.
REQ-034 data_out, out_err and the FSM state SHALL change only at rising clk edges; all outputs are glitch-free registers except in_ready.

Reset
REQ-035 While reset=0, the block SHALL force state=EMPTY, data_out=0, out_valid=0, out_err=0, stall_cnt=0 and the pending code to 0, immediately and independent of clk.
REQ-036 Reset asserted in STALL or HOLD SHALL discard the pending or held result; no result is emitted after release.
REQ-037 On the first edge after release, the block SHALL accept with in_ready=1.

Verification
REQ-038 Directed test: ADD, alu_out=0x0000_0005, out_ready=1 -> next cycle out_valid=1, data_out=0x0000_0005, out_err=0.
REQ-039 Directed test: SLT with cout=0, then SLT with cout=1, back-to-back with out_ready=1 -> data_out=0x0000_0001, then 0x0000_0000, on consecutive cycles.
REQ-040 Directed test: MFHI with mul_busy=1 for 3 cycles, hi_out=0xDEAD_BEEF when busy drops -> STALL for 3 cycles, stall_cnt=3, then data_out=0xDEAD_BEEF, in_ready=0 throughout the stall.
REQ-041 Directed test: result held with out_ready=0 for 4 cycles while in_valid=1 -> data_out stable, in_ready=0, no op lost; after out_ready=1 the next op appears one cycle later.
REQ-042 Directed test: signal=111111 -> data_out=0, out_err=1; CNT_W=2 with a 6-cycle stall -> stall_cnt saturates at 3.
REQ-043 Directed test: reset asserted mid-STALL -> all outputs immediately 0, state EMPTY, and no result after release.
